// File: rtl/simddr_mc.sv
// Simulated DDR memory controller: round-robin arbiter over NUM_CH requesters,
// one access in flight, fixed single/burst latency, internal beat-wide storage.
module simddr_mc #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 19,
  parameter int BEAT_W     = 64,
  parameter int BURST_LEN  = 8,
  parameter int SINGLE_LAT = 64,
  parameter int BURST_LAT  = 80,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_CH-1:0]                     req_valid,
  output logic [NUM_CH-1:0]                     req_ready,
  input  logic [NUM_CH-1:0]                     req_write,
  input  logic [NUM_CH-1:0]                     req_burst,
  input  logic [NUM_CH*ADDR_W-1:0]              req_index,
  input  logic [NUM_CH*BEAT_W-1:0]              req_wmask,
  input  logic [NUM_CH*BURST_LEN*BEAT_W-1:0]    req_wdata,
  output logic [NUM_CH-1:0]                     resp_valid,
  output logic [BURST_LEN*BEAT_W-1:0]           resp_rdata,
  output logic                                  busy
);
  localparam int MW  = $clog2(MEM_DEPTH);
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAXL = (SINGLE_LAT > BURST_LAT) ? SINGLE_LAT : BURST_LAT;
  localparam int LW  = $clog2(MAXL + 1);
  localparam int DW  = BURST_LEN * BEAT_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_ch, r_ptr, w_gnt_ch;
  logic [LW-1:0]       r_cnt;
  logic                r_write, r_burst, w_gnt_vld, w_grant, w_term;
  logic [MW-1:0]       r_index;
  logic [BEAT_W-1:0]   r_wmask;
  logic [DW-1:0]       r_wdata, r_rdata, w_rd;
  logic [MW-1:0]       w_addr [BURST_LEN];
  logic [BEAT_W-1:0]   r_mem [MEM_DEPTH];

  // Search starts at r_ptr, the channel after the last one granted.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_gnt_vld && req_valid[(int'(r_ptr) + i) % NUM_CH]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = CW'((int'(r_ptr) + i) % NUM_CH);
      end
    end
  end

  assign w_grant = !reset && (r_state == S_IDLE) && w_gnt_vld;
  assign w_term  = (r_cnt == (r_burst ? LW'(BURST_LAT) : LW'(SINGLE_LAT)));

  for (genvar k = 0; k < BURST_LEN; k++) begin : g_addr
    assign w_addr[k] = r_index + MW'(k);
  end

  always_comb begin
    w_rd = '0;
    for (int k = 0; k < BURST_LEN; k++)
      if (r_burst || k == 0) w_rd[k*BEAT_W +: BEAT_W] = r_mem[w_addr[k]];
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_next = S_WAIT;
      S_WAIT:  if (w_term)  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = 1'b0;
    if (!reset) begin
      if (w_grant) req_ready[w_gnt_ch] = 1'b1;
      if (r_state == S_RESP) resp_valid[r_ch] = 1'b1;
      busy = (r_state != S_IDLE);
    end
  end

  // Read data is captured on the last wait cycle so it is stable throughout RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_ch    <= '0;
      r_write <= 1'b0;
      r_burst <= 1'b0;
      r_index <= '0;
      r_wmask <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (w_grant) begin
      r_ch    <= w_gnt_ch;
      r_ptr   <= (w_gnt_ch == CW'(NUM_CH - 1)) ? '0 : w_gnt_ch + 1'b1;
      r_write <= req_write[w_gnt_ch];
      r_burst <= req_burst[w_gnt_ch];
      r_index <= req_index[w_gnt_ch*ADDR_W +: MW];
      r_wmask <= req_wmask[w_gnt_ch*BEAT_W +: BEAT_W];
      r_wdata <= req_wdata[w_gnt_ch*DW +: DW];
      r_cnt   <= LW'(1);
    end else if (r_state == S_WAIT) begin
      if (w_term) begin
        r_cnt <= '0;
        if (!r_write) r_rdata <= w_rd;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; a reset during RESP suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && r_state == S_RESP && r_write) begin
      if (r_burst) begin
        for (int k = 0; k < BURST_LEN; k++)
          r_mem[w_addr[k]] <= r_wdata[k*BEAT_W +: BEAT_W];
      end else begin
        r_mem[r_index] <= (r_mem[r_index] & ~r_wmask) | (r_wdata[BEAT_W-1:0] & r_wmask);
      end
    end
  end

  assign resp_rdata = r_rdata;
endmodule

// File: tb/tb_simddr_mc.sv
// Randomized + directed bench for simddr_mc against an array-based memory model.
module tb_simddr_mc;
  localparam int NUM_CH = 2, ADDR_W = 19, BEAT_W = 64, BL = 8;
  localparam int SLAT = 64, BLAT = 80, DEPTH = 4096;
  localparam int DW = BL * BEAT_W;

  logic                      clock = 1'b0, reset = 1'b1;
  logic [NUM_CH-1:0]         req_valid = '0, req_ready, req_write = '0, req_burst = '0;
  logic [NUM_CH*ADDR_W-1:0]  req_index = '0;
  logic [NUM_CH*BEAT_W-1:0]  req_wmask = '0;
  logic [NUM_CH*DW-1:0]      req_wdata = '0;
  logic [NUM_CH-1:0]         resp_valid;
  logic [DW-1:0]             resp_rdata;
  logic                      busy;

  simddr_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BURST_LEN(BL),
              .SINGLE_LAT(SLAT), .BURST_LAT(BLAT), .MEM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_burst(req_burst), .req_index(req_index),
    .req_wmask(req_wmask), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .busy(busy));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference memory: value plus a flag saying whether the beat is known.
  logic [BEAT_W-1:0] m_mem [DEPTH];
  bit                m_known [DEPTH];
  logic [DW-1:0]     last_exp = '0, last_msk = '1;

  function automatic logic [DW-1:0] rnd_dw();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_write(input bit bs, input int idx,
                                      input logic [BEAT_W-1:0] msk, input logic [DW-1:0] wd);
    int a;
    if (bs) begin
      for (int k = 0; k < BL; k++) begin
        a = (idx + k) % DEPTH;
        m_mem[a] = wd[k*BEAT_W +: BEAT_W];
        m_known[a] = 1'b1;
      end
    end else begin
      a = idx % DEPTH;
      if (m_known[a]) m_mem[a] = (m_mem[a] & ~msk) | (wd[BEAT_W-1:0] & msk);
      else if (msk == '1) begin m_mem[a] = wd[BEAT_W-1:0]; m_known[a] = 1'b1; end
    end
  endfunction

  function automatic void model_read(input bit bs, input int idx,
                                     output logic [DW-1:0] e, output logic [DW-1:0] m);
    int a;
    e = '0; m = '0;
    for (int k = 0; k < BL; k++) begin
      a = (idx + k) % DEPTH;
      if (bs || k == 0) begin
        if (m_known[a]) begin e[k*BEAT_W +: BEAT_W] = m_mem[a]; m[k*BEAT_W +: BEAT_W] = '1; end
      end else m[k*BEAT_W +: BEAT_W] = '1;
    end
  endfunction

  task automatic drive(input int ch, input bit wr, input bit bs, input int idx,
                       input logic [BEAT_W-1:0] msk, input logic [DW-1:0] wd);
    req_valid[ch] = 1'b1;
    req_write[ch] = wr;
    req_burst[ch] = bs;
    req_index[ch*ADDR_W +: ADDR_W] = ADDR_W'(idx);
    req_wmask[ch*BEAT_W +: BEAT_W] = msk;
    req_wdata[ch*DW +: DW] = wd;
  endtask

  // Present a request and wait (bounded) until it is granted; c0 = cycles before the grant edge.
  task automatic present(input int ch, input bit wr, input bit bs, input int idx,
                         input logic [BEAT_W-1:0] msk, input logic [DW-1:0] wd,
                         output int c0, output bit ok);
    @(negedge clock);
    drive(ch, wr, bs, idx, msk, wd);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      #1;
      if (req_ready[ch]) ok = 1'b1;
      else @(negedge clock);
    end
    c0 = cyc;
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_resp(input int c0, output bit ok);
    ok = 1'b0;
    while (!ok && cyc - c0 < 300) begin
      @(negedge clock);
      if (resp_valid != '0) ok = 1'b1;
    end
    if (!ok) chk("resp_timeout", 0, 1);
  endtask

  task automatic access(input int ch, input bit wr, input bit bs, input int idx,
                        input logic [BEAT_W-1:0] msk, input logic [DW-1:0] wd);
    int c0; bit ok;
    logic [DW-1:0] e, m;
    present(ch, wr, bs, idx, msk, wd, c0, ok);
    if (!ok) return;
    @(posedge clock); #1;
    // Scramble the inputs right after grant: only the latched request may matter.
    req_valid[ch] = 1'b0;
    req_index[ch*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    req_wdata[ch*DW +: DW] = rnd_dw();
    req_wmask[ch*BEAT_W +: BEAT_W] = {$urandom, $urandom};
    @(negedge clock);
    chk("busy_wait", DW'(busy), 1);
    wait_resp(c0, ok);
    if (!ok) return;
    chk("latency", DW'(cyc - c0), DW'((bs ? BLAT : SLAT) + 1));
    chk("resp_owner", DW'(resp_valid), DW'(1 << ch));
    if (wr) begin
      model_write(bs, idx, msk, wd);
      chk("wr_rdata_hold", resp_rdata & last_msk, last_exp & last_msk);
    end else begin
      model_read(bs, idx, e, m);
      chk(bs ? "burst_rdata" : "single_rdata", resp_rdata & m, e & m);
      last_exp = e; last_msk = m;
    end
    @(negedge clock);
    chk("resp_pulse_end", DW'(resp_valid), 0);
    chk("busy_idle", DW'(busy), 0);
  endtask

  logic [DW-1:0] pat, pat2;
  int c0, cnt;
  bit ok;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clock);
    chk("rst_ready", DW'(req_ready), 0);
    chk("rst_resp", DW'(resp_valid), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_rdata", resp_rdata, 0);
    req_valid = '0;
    reset = 1'b0;

    // Single full write then read; mask-limited overwrite.
    access(0, 1, 0, 5, '1, DW'(64'h1122334455667788));
    access(0, 0, 0, 5, '0, '0);
    chk("d033_beat0", resp_rdata, DW'(64'h1122334455667788));
    access(1, 1, 0, 5, 64'h00000000FFFFFFFF, '1);
    access(1, 0, 0, 5, '0, '0);
    chk("d034_masked", resp_rdata, DW'(64'h11223344FFFFFFFF));
    access(0, 1, 0, 5, '0, DW'(64'hDEAD));
    access(0, 0, 0, 5, '0, '0);
    chk("zero_mask", resp_rdata, DW'(64'h11223344FFFFFFFF));

    // Burst wrapping past the top of memory.
    for (int k = 0; k < BL; k++) pat[k*BEAT_W +: BEAT_W] = BEAT_W'(k);
    access(1, 1, 1, DEPTH - 2, '0, pat);
    access(0, 0, 1, DEPTH - 2, '0, '0);
    chk("d035_burst", resp_rdata, pat);
    access(0, 0, 0, 0, '0, '0);
    chk("d035_wrap0", resp_rdata, DW'(2));

    // Reset 10 cycles into a burst write aborts it.
    pat = rnd_dw();
    access(0, 1, 1, 40, '0, pat);
    pat2 = rnd_dw();
    present(1, 1, 1, 40, '0, pat2, c0, ok);
    @(posedge clock); #1; req_valid = '0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", DW'(busy), 0);
    chk("abort_rdata", resp_rdata, 0);
    reset = 1'b0;
    last_exp = '0; last_msk = '1;
    cnt = 0;
    repeat (120) begin @(negedge clock); if (resp_valid != '0) cnt++; end
    chk("abort_no_resp", DW'(cnt), 0);
    access(1, 0, 1, 40, '0, '0);
    chk("abort_mem_kept", resp_rdata, pat);

    // Simultaneous requests after reset: channel 0 first, channel 1 after its response.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_exp = '0; last_msk = '1;
    @(negedge clock);
    drive(0, 1, 0, 20, '1, DW'(64'hAAAA0000));
    drive(1, 1, 0, 21, '1, DW'(64'hBBBB1111));
    #1;
    chk("rr_first", DW'(req_ready), 2'b01);
    c0 = cyc;
    @(posedge clock); #1; req_valid[0] = 1'b0;
    wait_resp(c0, ok);
    chk("rr_resp0", DW'(resp_valid), 2'b01);
    chk("rr_no_grant_in_resp", DW'(req_ready), 0);
    @(negedge clock);
    chk("rr_second", DW'(req_ready), 2'b10);
    chk("rr_resp_gone", DW'(resp_valid), 0);
    c0 = cyc;
    @(posedge clock); #1; req_valid[1] = 1'b0;
    wait_resp(c0, ok);
    chk("rr_resp1", DW'(resp_valid), 2'b10);
    chk("rr_lat1", DW'(cyc - c0), DW'(SLAT + 1));
    model_write(0, 20, '1, DW'(64'hAAAA0000));
    model_write(0, 21, '1, DW'(64'hBBBB1111));
    access(1, 0, 0, 20, '0, '0);
    access(0, 0, 0, 21, '0, '0);

    // Random traffic over a low window and a window wrapping the top of memory.
    for (int n = 0; n < 40; n++) begin
      int idx;
      idx = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : DEPTH - 16 + $urandom_range(0, 15);
      access($urandom_range(0, NUM_CH - 1), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
             idx, ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom}, rnd_dw());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/simddr_mc.md
SIMDDR_MC -- requirements
Module: simddr_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent requester channels.
REQ-002 SHALL have parameter ADDR_W, default 19: beat-index width.
REQ-003 SHALL have parameter BEAT_W, default 64: bits per beat.
REQ-004 SHALL have parameter BURST_LEN, default 8: beats per burst access.
REQ-005 SHALL have parameter SINGLE_LAT, default 64: cycles from grant to response for a single-beat access (>=1).
REQ-006 SHALL have parameter BURST_LAT, default 80: cycles from grant to response for a burst access (>=1).
REQ-007 SHALL have parameter MEM_DEPTH, default 4096: beats of internal storage (power of two); index wraps modulo MEM_DEPTH.
REQ-008 SHALL have port clock, input, 1: sole clock, all logic on rising edge.
REQ-009 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-010 SHALL have port req_valid, input, NUM_CH: per-channel request valid.
REQ-011 SHALL have port req_ready, output, NUM_CH: per-channel request accepted this cycle.
REQ-012 SHALL have port req_write, input, NUM_CH: 1 write, 0 read.
REQ-013 SHALL have port req_burst, input, NUM_CH: 1 burst (BURST_LEN beats), 0 single beat.
REQ-014 SHALL have port req_index, input, NUM_CH*ADDR_W: start beat index, channel c at slice c.
REQ-015 SHALL have port req_wmask, input, NUM_CH*BEAT_W: bit write mask, single writes only.
REQ-016 SHALL have port req_wdata, input, NUM_CH*BURST_LEN*BEAT_W: write data; beat k at bits [k*BEAT_W +: BEAT_W] of channel slice; single writes use beat 0.
REQ-017 SHALL have port resp_valid, output, NUM_CH: one-cycle completion pulse to the owning channel.
REQ-018 SHALL have port resp_rdata, output, BURST_LEN*BEAT_W: read data, shared; single reads in beat 0, upper beats zero.
REQ-019 SHALL have port busy, output, 1: high while an access is outstanding.

Function
REQ-020 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; one access outstanding at a time.
REQ-021 In IDLE with any req_valid set, SHALL grant exactly one channel by round-robin starting after the last granted channel (channel 0 first after reset); req_ready pulses for that channel only, same cycle.
REQ-022 On grant SHALL latch write, burst, index, wmask, wdata and channel id; later input changes SHALL NOT affect the access.
REQ-023 WAIT SHALL count from 1 to SINGLE_LAT or BURST_LAT per latched burst flag; at terminal count move to RESP.
REQ-024 In RESP SHALL perform the memory operation, assert resp_valid for the latched channel for exactly one cycle, then return to IDLE; total grant-to-resp_valid latency = LAT+1 cycles.
REQ-025 Burst read SHALL return beats index+k, k=0..BURST_LEN-1, each index wrapped modulo MEM_DEPTH; burst write SHALL write all beats unmasked.
REQ-026 Single write SHALL update mem[index] = (old & ~wmask) | (wdata & wmask); wmask all-zero leaves memory unchanged.
REQ-027 Write accesses SHALL leave resp_rdata unchanged; resp_rdata SHALL hold its last value until the next read response.
REQ-028 req_ready SHALL be zero in WAIT and RESP; a request arriving then stays pending (requester holds req_valid) and is arbitrated in the next IDLE cycle.
REQ-029 busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-030 A request presented for the cycle in which resp_valid pulses SHALL NOT be granted that cycle (earliest grant is the following cycle).

Reset
REQ-031 When reset is high, SHALL enter IDLE; req_ready, resp_valid, busy = 0; resp_rdata = 0; counter = 0; round-robin pointer = channel 0.
REQ-032 Reset mid-access SHALL abort it: no memory update, no resp_valid; memory contents otherwise preserved (not cleared by reset).

Verification
REQ-033 Single write idx 5, wdata 0x1122334455667788, wmask all-ones; then single read idx 5 -> resp_valid at grant+65, rdata beat0 = 0x1122334455667788, beats 1..7 = 0.
REQ-034 Write idx 5 data 0xFFFF..FF mask 0x00000000FFFFFFFF over prior 0x1122334455667788; read -> 0x11223344FFFFFFFF.
REQ-035 Burst write idx MEM_DEPTH-2, beats 0..7 = 0..7; burst read same idx -> resp_valid at grant+81, beat k = k, with beats 2..7 stored at idx 0..5.
REQ-036 Both channels assert req_valid together, held until resp -> ch0 granted first, ch1 granted cycle after ch0's resp_valid; resp_valid never on both bits.
REQ-037 Reset asserted 10 cycles into a burst write -> no resp_valid, target beats retain old values, busy = 0 next cycle.
REQ-038 Change req_index/req_wdata one cycle after grant -> memory reflects latched values only.
